div_seq_ctrl: RTL and testbench

- Multi-cycle controller for the team's 16-bit signed divider datapath.
- Accepts one dividend/divisor pair over a valid/ready handshake.
- Sequences a radix-2 restoring divide at one quotient bit per clock, applies sign fix-up, then holds the result until the consumer takes it.
- Replaces the single-cycle combinational divider in the MIPS-16 ALU path so the divide is off the critical timing path.

---
 rtl/div_pkg.sv | 33 +++
 rtl/div_step.sv | 34 +++
 rtl/div_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_div_seq_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE,
    ITER,
    FIX,
    DZ,
    DONE
  } state_t;

  localparam int DIV_WIDTH_DEF = 16;

  // Quotient reported on divide-by-zero. Slice the low WIDTH bits (WIDTH <= 64).
  localparam logic [63:0] DZ_QUO_ALL = '1;

  // Ceiling log2. Never returns less than 1, so a counter always has one bit.
  function automatic int div_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide step: shift {p,a} left, trial-subtract b, keep or restore.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of its inputs).
// Ports: p/a = partial remainder and quotient shift register in,
//        b = divisor magnitude, p_nxt/a_nxt = values after this step.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   p_nxt,
  output logic [WIDTH-1:0] a_nxt
);

  // Carry one extra bit so the sign of the trial subtraction is explicit.
  logic [WIDTH+1:0] p_sh;
  logic [WIDTH+1:0] trial;

  always_comb begin
    p_sh  = {p, a[WIDTH-1]};
    trial = p_sh - {2'b00, b};
    if (!trial[WIDTH+1]) begin
      p_nxt = trial[WIDTH:0];
      a_nxt = {a[WIDTH-2:0], 1'b1};
    end else begin
      p_nxt = p_sh[WIDTH:0];
      a_nxt = {a[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed (truncating) divider: one quotient bit per clock, then sign fix-up.
// Latency: accept edge to out_valid = WIDTH+2 cycles counting both edges (divide-by-zero: 2).
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
// Ports: clk, rst_n (async active-low); in_valid/in_ready + dividend/divisor operand
//        handshake; out_valid/out_ready + quo/rem/dz result handshake.
// Build option: define DIV_B2B_EN to accept a new operand pair in DONE on the
//        same edge the current result is taken (back-to-back operation).
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dz
);

  localparam int CW = div_clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sq_q;
  logic             sr_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] a_step;
  logic             accept;
  logic             div_zero;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  // Unsigned magnitudes; the most negative value maps onto itself, which is
  // exactly 2^(WIDTH-1) when read as unsigned.
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign div_zero     = (divisor == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .p     (p_q),
    .a     (a_q),
    .b     (b_q),
    .p_nxt (p_step),
    .a_nxt (a_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
`ifdef DIV_B2B_EN
      DONE: in_ready = out_ready;
`else
      DONE: in_ready = 1'b0;
`endif
      default: in_ready = 1'b0;
    endcase

    accept = in_valid & in_ready;

    case (state)
      IDLE: if (accept) state_nxt = div_zero ? DZ : ITER;
      ITER: if (cnt_q == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DZ:   state_nxt = DONE;
      DONE: begin
        // accept can only be true here in the back-to-back build
        if (accept)         state_nxt = div_zero ? DZ : ITER;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Divide datapath. On a zero divisor the raw dividend is parked in a_q so
  // the DZ state can return it as the remainder without another register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sq_q  <= 1'b0;
      sr_q  <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      p_q   <= '0;
      a_q   <= div_zero ? dividend : dividend_mag;
      b_q   <= divisor_mag;
      sq_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sr_q  <= dividend[WIDTH-1];
      cnt_q <= '0;
    end else if (state == ITER) begin
      p_q   <= p_step;
      a_q   <= a_step;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Result registers: written only when leaving FIX or DZ, so they stay
  // stable for the whole DONE residency and after the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo       <= '0;
      rem       <= '0;
      dz        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FIX: begin
          quo       <= sq_q ? -a_q : a_q;
          rem       <= sr_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
          dz        <= 1'b0;
          out_valid <= 1'b1;
        end
        DZ: begin
          quo       <= DZ_QUO_ALL[WIDTH-1:0];
          rem       <= a_q;
          dz        <= 1'b1;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: hand-computed quotient/remainder vectors,
// latency, stall behaviour, divide-by-zero and mid-operation reset.
module tb_div_seq_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         dz;

  int checks = 0;
  int errors = 0;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo       (quo),
    .rem       (rem),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic start_op(input string tag, input logic [W-1:0] dd, input logic [W-1:0] dv);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 16'h0BAD;
  endtask

  // Latency counts the accept edge as 1 and the out_valid edge inclusively.
  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic d);
    chk({tag, "_quo"}, {16'd0, quo}, {16'd0, q});
    chk({tag, "_rem"}, {16'd0, rem}, {16'd0, r});
    chk({tag, "_dz"},  {31'd0, dz},  {31'd0, d});
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_retired"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [W-1:0] dd, input logic [W-1:0] dv,
                     input logic [W-1:0] q, input logic [W-1:0] r, input logic d,
                     input int lat);
    start_op(tag, dd, dv);
    wait_result(tag, lat);
    check_res(tag, q, r, d);
    retire(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quo", {16'd0, quo}, 32'd0);
    chk("rst_rem", {16'd0, rem}, 32'd0);
    chk("rst_dz",  {31'd0, dz},  32'd0);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Signed truncating vectors
    run("p100_p7",   16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 18);
    run("m100_p7",   16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 18);
    run("p100_m7",   16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 18);
    run("min_m1",    16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 18);
    run("min_p1",    16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 18);
    run("m7_p2",     16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 18);
    run("p5_zero",   16'd5,    16'd0,    16'hFFFF, 16'h0005, 1'b1, 2);

    // Consumer stall: result and in_ready must hold while out_ready is low
    start_op("stall", 16'd1000, 16'd3);
    wait_result("stall", 18);
    in_valid = 1'b1;
    dividend = 16'd7;
    divisor  = 16'd1;
    for (int i = 0; i < 10; i++) begin
      chk("stall_quo", {16'd0, quo}, 32'd333);
      chk("stall_rem", {16'd0, rem}, 32'd1);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    dividend  = 16'd50;
    divisor   = 16'd6;
`ifdef DIV_B2B_EN
    chk("b2b_in_ready_comb", {31'd0, in_ready}, 32'd1);
`endif
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("stall_drop", {31'd0, out_valid}, 32'd0);
`ifdef DIV_B2B_EN
    chk("b2b_busy", {31'd0, in_ready}, 32'd0);
    wait_result("b2b", 18);
    check_res("b2b", 16'd8, 16'd2, 1'b0);
    retire("b2b");
`else
    chk("base_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("base_no_start", {31'd0, out_valid}, 32'd0);
    chk("base_still_idle", {31'd0, in_ready}, 32'd1);
`endif

    // Reset in the middle of an operation
    start_op("midrst", 16'd1234, 16'd5);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_quo", {16'd0, quo}, 32'd0);
    chk("midrst_rem", {16'd0, rem}, 32'd0);
    chk("midrst_dz",  {31'd0, dz},  32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_no_result", {31'd0, out_valid}, 32'd0);
    run("after_rst", 16'd1234, 16'd5, 16'd246, 16'd4, 1'b0, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
